lsu_mem: RTL

Parametrised load/store data memory with a request/acknowledge handshake, byte/half/word/doubleword access, sign or zero extension and configurable read latency. It sits between the execute stage and data storage as the successor to the fixed four-lane byte memory. It lets the core stall on memory instead of assuming a same-cycle read. Storage is a word array addressed by byte address; lanes are selected internally.

---
 rtl/lsu_mem.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem.sv
// lsu_mem: load/store data memory with req/ack handshake, byte/half/word/dword
// access, sign or zero extension on loads and a configurable read latency.
// Storage is a word array addressed by byte address; byte lanes are selected
// internally from the low address bits.
// Optional feature macro: LSU_MEM_INIT_EN -- when defined, leaving reset walks
// the whole array writing zeros (CLEAR state) before the first access.
module lsu_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rstd,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              ack,
  output logic              err,
  output logic [DATA_W-1:0] rdata
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int IDX_W  = ADDR_W - LANE_W;
  localparam int DEPTH  = 1 << IDX_W;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RD    = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;
`ifdef LSU_MEM_INIT_EN
  localparam logic [1:0] CLEAR = 2'd3;
`endif

  localparam logic [1:0] CNT_INIT = 2'(LAT - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        state;
  logic [1:0]        cnt;
  logic [1:0]        ld_size;
  logic              ld_sext;
  logic [ADDR_W-1:0] ld_addr;
`ifdef LSU_MEM_INIT_EN
  logic [IDX_W-1:0]  clr_idx;
`endif

  logic [ADDR_W-1:0] align_mask;
  logic              misaligned;
  logic              too_wide;
  logic              bad;
  logic              accepting;
  logic              do_store;

  logic [LANE_W-1:0] st_lane;
  logic [IDX_W-1:0]  st_idx;
  logic [NB-1:0]     st_mask;
  logic [DATA_W-1:0] st_data;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [NB-1:0]     mem_mask;
  logic [DATA_W-1:0] mem_wdata;

  logic [LANE_W-1:0] ld_lane;
  logic [DATA_W-1:0] ld_word;
  logic [DATA_W-1:0] ld_shift;
  logic [DATA_W-1:0] ld_val;
  logic              ld_top;
  logic              ld_fill;

  // Classify the incoming request: alignment/width errors and acceptance.
  always_comb begin
    align_mask = (ADDR_W'(1) << size) - ADDR_W'(1);
    misaligned = |(addr & align_mask);
    too_wide   = (int'(size) > LANE_W);
    bad        = misaligned | too_wide;
    accepting  = rstd & req & ((state == IDLE) | (state == RESP));
    do_store   = accepting & we & ~bad;
  end

  // Place right-justified store data onto the addressed byte lanes.
  always_comb begin
    st_lane = addr[LANE_W-1:0];
    st_idx  = addr[ADDR_W-1:LANE_W];
    st_data = wdata << {st_lane, 3'b000};
    st_mask = '0;
    for (int b = 0; b < NB; b++) begin
      if ((b >= int'(st_lane)) && (b < int'(st_lane) + (1 << size))) begin
        st_mask[b] = 1'b1;
      end
    end
  end

  // Select the array write source: an accepted store or the clear sweep.
  always_comb begin
    mem_we    = do_store;
    mem_idx   = st_idx;
    mem_mask  = st_mask;
    mem_wdata = st_data;
`ifdef LSU_MEM_INIT_EN
    if (rstd && (state == CLEAR)) begin
      mem_we    = 1'b1;
      mem_idx   = clr_idx;
      mem_mask  = '1;
      mem_wdata = '0;
    end
`endif
  end

  // Byte-lane write into the array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_mask[b]) begin
          mem[mem_idx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Extract the captured load's lanes and extend them to a full word.
  always_comb begin
    ld_lane  = ld_addr[LANE_W-1:0];
    ld_word  = mem[ld_addr[ADDR_W-1:LANE_W]];
    ld_shift = ld_word >> {ld_lane, 3'b000};
    ld_top   = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i == (8 << ld_size) - 1) begin
        ld_top = ld_shift[i];
      end
    end
    ld_fill = ld_sext & ld_top;
    ld_val  = '0;
    for (int i = 0; i < DATA_W; i++) begin
      ld_val[i] = (i < (8 << ld_size)) ? ld_shift[i] : ld_fill;
    end
  end

  // Access sequencer: accept in IDLE/RESP, count load latency, pulse ack.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
`ifdef LSU_MEM_INIT_EN
      state   <= CLEAR;
      clr_idx <= '0;
`else
      state   <= IDLE;
`endif
      cnt     <= 2'd0;
      busy    <= 1'b0;
      ack     <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      ld_size <= 2'd0;
      ld_sext <= 1'b0;
      ld_addr <= '0;
    end else begin
      ack   <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
      case (state)
        RD: begin
          if (cnt == 2'd0) begin
            state <= RESP;
            busy  <= 1'b0;
            ack   <= 1'b1;
            rdata <= ld_val;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
`ifdef LSU_MEM_INIT_EN
        CLEAR: begin
          if (clr_idx == '1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            clr_idx <= clr_idx + IDX_W'(1);
            busy    <= 1'b1;
          end
        end
`endif
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (req) begin
            if (bad) begin
              state <= RESP;
              ack   <= 1'b1;
              err   <= 1'b1;
            end else if (we) begin
              state <= RESP;
              ack   <= 1'b1;
            end else begin
              state   <= RD;
              busy    <= 1'b1;
              cnt     <= CNT_INIT;
              ld_size <= size;
              ld_sext <= sext;
              ld_addr <= addr;
            end
          end
        end
      endcase
    end
  end

endmodule
